// File: rtl/fifo_sched_pkg.sv
// Shared types and constants for the single-port FIFO access scheduler.
// Imported by the scheduler top and its testbench.
package fifo_sched_pkg;

  typedef enum logic {
    PRIO_WR = 1'b0,
    PRIO_RD = 1'b1
  } prio_e;

  localparam int DW_DEF = 8;

  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_access_sched_rr_arbiter.sv
// Round-robin writer selector.
// The search starts at rr and the first requester found wins.
module rr_arbiter #(
  parameter int NW = 2,
  parameter int IW = (NW > 1) ? $clog2(NW) : 1
) (
  input  logic [NW-1:0] req,
  input  logic [IW-1:0] rr,
  output logic [NW-1:0] gnt,
  output logic [IW-1:0] idx
);

  logic found;
  int   j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < NW; i++) begin
      j = (int'(rr) + i) % NW;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_access_sched.sv
// Shares a single-port FIFO between NW writers and one reader.
// A shadow count guards the FIFO against overflow and underflow.
module fifo_access_sched
  import fifo_sched_pkg::*;
#(
  parameter int NW    = 2,
  parameter int DW    = DW_DEF,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [NW-1:0]              wr_req,
  input  logic [NW*DW-1:0]           wr_data,
  output logic [NW-1:0]              wr_gnt,
  input  logic                       rd_req,
  output logic                       rd_gnt,
  output logic                       rd_valid,
  output logic [DW-1:0]              rd_data,
  output logic                       fifo_en,
  output logic                       fifo_wr_rd,
  output logic [DW-1:0]              fifo_din,
  input  logic [DW-1:0]              fifo_dout,
  output logic [lvl_w(DEPTH)-1:0]    level
);

  localparam int LW = lvl_w(DEPTH);
  localparam int IW = (NW > 1) ? $clog2(NW) : 1;

  prio_e         state;
  prio_e         state_nx;
  logic [IW-1:0] rr;
  logic [IW-1:0] arb_idx;
  logic [NW-1:0] arb_gnt;
  logic          wr_elig;
  logic          rd_elig;
  logic          do_wr;
  logic          do_rd;
  logic [1:0]    rd_pipe;

  rr_arbiter #(
    .NW(NW),
    .IW(IW)
  ) u_arb (
    .req(wr_req),
    .rr (rr),
    .gnt(arb_gnt),
    .idx(arb_idx)
  );

  // Grants are held off while reset is asserted.
  always_comb begin
    wr_elig  = rstn && (|wr_req) && (level < LW'(DEPTH));
    rd_elig  = rstn && rd_req && (level != '0);
    do_wr    = wr_elig && (!rd_elig || (state == PRIO_WR));
    do_rd    = rd_elig && !do_wr;
    state_nx = state;
    if (wr_elig && rd_elig) begin
      state_nx = (state == PRIO_WR) ? PRIO_RD : PRIO_WR;
    end
    wr_gnt = do_wr ? arb_gnt : '0;
    rd_gnt = do_rd;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= PRIO_WR;
      rr         <= '0;
      level      <= '0;
      fifo_en    <= 1'b0;
      fifo_wr_rd <= 1'b0;
      fifo_din   <= '0;
      rd_pipe    <= '0;
    end else begin
      state   <= state_nx;
      rd_pipe <= {rd_pipe[0], do_rd};
      fifo_en <= do_wr | do_rd;
      unique case (1'b1)
        do_wr: begin
          level      <= level + LW'(1);
          fifo_wr_rd <= 1'b1;
          fifo_din   <= wr_data[int'(arb_idx)*DW +: DW];
          rr         <= (int'(arb_idx) == NW - 1) ? '0 : arb_idx + IW'(1);
        end
        do_rd: begin
          level      <= level - LW'(1);
          fifo_wr_rd <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign rd_valid = rd_pipe[1];
  assign rd_data  = fifo_dout;

endmodule

// File: tb/tb_fifo_access_sched.sv
// Directed bench for fifo_access_sched with a behavioural FIFO
// attached and a scoreboard built from the expected grants.
module tb_fifo_access_sched;
  import fifo_sched_pkg::*;

  logic        clk;
  logic        rstn;
  logic [1:0]  wr_req;
  logic [15:0] wr_data;
  logic [1:0]  wr_gnt;
  logic        rd_req;
  logic        rd_gnt;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        fifo_en;
  logic        fifo_wr_rd;
  logic [7:0]  fifo_din;
  logic [7:0]  fifo_dout;
  logic [4:0]  level;

  int checks;
  int failures;

  fifo_access_sched #(
    .NW(2),
    .DW(8),
    .DEPTH(16)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .wr_req    (wr_req),
    .wr_data   (wr_data),
    .wr_gnt    (wr_gnt),
    .rd_req    (rd_req),
    .rd_gnt    (rd_gnt),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .fifo_en   (fifo_en),
    .fifo_wr_rd(fifo_wr_rd),
    .fifo_din  (fifo_din),
    .fifo_dout (fifo_dout),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port FIFO driven by the scheduler.
  logic [7:0] fq[$];
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fq.delete();
      fifo_dout <= 8'h00;
    end else if (fifo_en) begin
      if (fifo_wr_rd) fq.push_back(fifo_din);
      else if (fq.size() > 0) fifo_dout <= fq.pop_front();
    end
  end

  // Reference state derived only from expected grants.
  logic [7:0] rq[$];
  int         elvl;
  logic       pen;
  logic       pwr;
  logic [7:0] pdin;
  logic [1:0] pvv;
  logic [7:0] pvd[2];

  task automatic ref_clear();
    rq.delete();
    elvl   = 0;
    pen    = 1'b0;
    pwr    = 1'b0;
    pdin   = 8'h00;
    pvv    = 2'b00;
    pvd[0] = 8'h00;
    pvd[1] = 8'h00;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    ref_clear();
    rstn    = 1'b0;
    wr_req  = 2'b11;
    wr_data = 16'hFFFF;
    rd_req  = 1'b1;
    #1;
    chk("rst_outs", 32'({wr_gnt, rd_gnt, rd_valid, fifo_en,
                         fifo_wr_rd, fifo_din, level}), 0);
    chk("rst_rr", 32'(dut.rr), 0);
    chk("rst_fsm", 32'(dut.state), 32'(PRIO_WR));
    @(posedge clk);
    #1;
    chk("rst_hold", 32'({wr_gnt, rd_gnt, rd_valid, fifo_en, level}), 0);
    wr_req  = 2'b00;
    wr_data = 16'h0000;
    rd_req  = 1'b0;
    rstn    = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One cycle: drive, check against reference, advance reference.
  task automatic cyc(input string nm, input logic [1:0] wreq,
                     input logic [7:0] d0, input logic [7:0] d1,
                     input logic rreq, input logic [1:0] ewg,
                     input logic erg);
    logic [7:0] pop;
    pop     = 8'h00;
    wr_req  = wreq;
    wr_data = {d1, d0};
    rd_req  = rreq;
    #2;
    chk({nm, "/wgnt"}, 32'(wr_gnt), 32'(ewg));
    chk({nm, "/rgnt"}, 32'(rd_gnt), 32'(erg));
    chk({nm, "/level"}, 32'(level), 32'(elvl));
    chk({nm, "/en"}, 32'(fifo_en), 32'(pen));
    if (pen) chk({nm, "/wr_rd"}, 32'(fifo_wr_rd), 32'(pwr));
    chk({nm, "/din"}, 32'(fifo_din), 32'(pdin));
    chk({nm, "/rvalid"}, 32'(rd_valid), 32'(pvv[1]));
    if (pvv[1]) chk({nm, "/rdata"}, 32'(rd_data), 32'(pvd[1]));
    if (ewg != 2'b00) begin
      pdin = ewg[0] ? d0 : d1;
      rq.push_back(pdin);
      elvl++;
      pen = 1'b1;
      pwr = 1'b1;
    end else if (erg) begin
      if (rq.size() > 0) pop = rq.pop_front();
      elvl--;
      pen = 1'b1;
      pwr = 1'b0;
    end else begin
      pen = 1'b0;
    end
    pvv[1] = pvv[0];
    pvd[1] = pvd[0];
    pvv[0] = erg;
    pvd[0] = pop;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0] wreq;
    logic       rreq;
    logic [1:0] ewg;
    logic       erg;
  } vec_t;

  vec_t tbl[11];

  initial begin
    checks   = 0;
    failures = 0;
    rstn     = 1'b0;
    wr_req   = 2'b00;
    wr_data  = 16'h0000;
    rd_req   = 1'b0;

    tbl[0]  = '{2'b00, 1'b1, 2'b00, 1'b0};
    tbl[1]  = '{2'b11, 1'b0, 2'b01, 1'b0};
    tbl[2]  = '{2'b11, 1'b0, 2'b10, 1'b0};
    tbl[3]  = '{2'b11, 1'b0, 2'b01, 1'b0};
    tbl[4]  = '{2'b10, 1'b0, 2'b10, 1'b0};
    tbl[5]  = '{2'b01, 1'b1, 2'b01, 1'b0};
    tbl[6]  = '{2'b01, 1'b1, 2'b00, 1'b1};
    tbl[7]  = '{2'b01, 1'b1, 2'b01, 1'b0};
    tbl[8]  = '{2'b00, 1'b1, 2'b00, 1'b1};
    tbl[9]  = '{2'b10, 1'b1, 2'b00, 1'b1};
    tbl[10] = '{2'b00, 1'b0, 2'b00, 1'b0};

    // Reset release with no traffic.
    do_reset();
    for (int i = 0; i < 10; i++) cyc("idle", 2'b00, 8'h00, 8'h00, 1'b0, 2'b00, 1'b0);

    // Mixed round-robin / priority vectors.
    for (int i = 0; i < 11; i++)
      cyc($sformatf("vec%0d", i), tbl[i].wreq, 8'(8'h10 + i),
          8'(8'h90 + i), tbl[i].rreq, tbl[i].ewg, tbl[i].erg);
    for (int i = 0; i < 2; i++) cyc("flush", 2'b00, 8'h00, 8'h00, 1'b0, 2'b00, 1'b0);

    // Fill to DEPTH, overflow attempt, drain to 8, then W/R alternation.
    do_reset();
    for (int i = 0; i < 16; i++)
      cyc($sformatf("fill%0d", i), 2'b01, 8'(i), 8'hEE, 1'b0, 2'b01, 1'b0);
    cyc("full_block", 2'b11, 8'h77, 8'h88, 1'b0, 2'b00, 1'b0);
    for (int i = 0; i < 8; i++)
      cyc($sformatf("drain%0d", i), 2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 1'b1);
    for (int i = 0; i < 6; i++)
      cyc($sformatf("alt%0d", i), 2'b01, 8'(8'h40 + i), 8'h00, 1'b1,
          (i % 2 == 0) ? 2'b01 : 2'b00, (i % 2 == 1));
    for (int i = 0; i < 3; i++) cyc("flush", 2'b00, 8'h00, 8'h00, 1'b0, 2'b00, 1'b0);

    // Empty read blocked, then write/read back-to-back turnaround.
    do_reset();
    cyc("empty_rd", 2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 1'b0);
    cyc("ta_wr", 2'b10, 8'h00, 8'hC3, 1'b0, 2'b10, 1'b0);
    cyc("ta_rd", 2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 1'b1);
    for (int i = 0; i < 3; i++) cyc("ta_wait", 2'b00, 8'h00, 8'h00, 1'b0, 2'b00, 1'b0);

    // Reset while a read is in flight discards it.
    do_reset();
    cyc("inf_wr", 2'b01, 8'h5A, 8'h00, 1'b0, 2'b01, 1'b0);
    cyc("inf_rd", 2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 1'b1);
    do_reset();
    for (int i = 0; i < 4; i++) cyc("post_rst", 2'b00, 8'h00, 8'h00, 1'b0, 2'b00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_access_sched.md
# fifo_access_sched

Scheduler that shares the single-port 8-bit FIFO (one write *or* one read per cycle, selected by a write/read strobe) between `NW` write requesters and one read requester. It performs round-robin arbitration among writers and alternating write/read priority when both sides contend. It keeps a shadow occupancy count so grants never overflow or underflow the FIFO. It sits directly in front of the FIFO and owns all of its control inputs.

## Interface
Parameters:
- `NW`, 2: number of write requesters (2..8)
- `DW`, 8: data width; matches the FIFO
- `DEPTH`, 16: FIFO depth in words; the shadow count saturates here

Ports:
- `clk` in 1: single clock, rising edge
- `rstn` in 1: reset, asynchronous, active-low
- `wr_req` in NW: per-writer request, level
- `wr_data` in NW*DW: writer i data in bits [i*DW +: DW]
- `wr_gnt` out NW: one-hot write grant, combinational, same cycle as the accepted request
- `rd_req` in 1: read request, level
- `rd_gnt` out 1: read grant, combinational
- `rd_valid` out 1: read data valid strobe
- `rd_data` out DW: read data, meaningful only while `rd_valid`=1
- `fifo_en` out 1: FIFO operation enable, registered
- `fifo_wr_rd` out 1: 1=write, 0=read, registered
- `fifo_din` out DW: write data to the FIFO, registered
- `fifo_dout` in DW: FIFO data_out
- `level` out clog2(DEPTH+1): shadow occupancy

## Operation
- Shadow count `level`:
  - +1 on a write grant, −1 on a read grant, unchanged otherwise.
  - At most one grant per cycle.
- Write eligibility: `|wr_req` and `level < DEPTH`.
- Read eligibility: `rd_req` and `level > 0`.
- Priority FSM, states PRIO_WR and PRIO_RD; reset state PRIO_WR.
  - Both sides eligible: grant the side named by the state, then move to the other state.
  - Only one side eligible: grant it; the state is unchanged.
  - Neither eligible: no grant; the state is unchanged.
- Writer selection:
  - Round-robin pointer `rr`, reset 0.
  - Search starts at `rr` and wraps modulo NW. The first requesting index wins.
  - After a write grant to index k, `rr` ← (k+1) mod NW.
  - `rr` is unchanged in cycles without a write grant.
- FIFO command register, loaded every cycle:
  - Grant: `fifo_en`=1, `fifo_wr_rd`=1 for a write grant or 0 for a read grant.
  - `fifo_din` = granted writer's data on a write; it holds its previous value otherwise.
  - No grant: `fifo_en`=0.
- Read return: a 2-stage shift of `rd_gnt` drives `rd_valid`. `rd_data` = `fifo_dout` (pass-through).
- A requester holding `req` without a grant keeps its request and data stable; they are resampled next cycle.
- Reset, mid-operation or otherwise:
  - Outputs: `wr_gnt`=0, `rd_gnt`=0, `rd_valid`=0, `fifo_en`=0, `fifo_wr_rd`=0, `fifo_din`=0, `level`=0.
  - Internal: `rr`=0, FSM=PRIO_WR, read pipe cleared.
  - Any in-flight read data is discarded. The FIFO must be reset by the same `rstn`.

## Timing
- Cycle t: requests sampled and grant driven combinationally. `level`, `rr` and FSM update at the end of t.
- Cycle t+1: `fifo_en`/`fifo_wr_rd`/`fifo_din` present. The FIFO acts at the edge ending t+1.
- Cycle t+2: `rd_valid`=1 and `rd_data` valid for a read granted in t.
- Throughput: one grant per cycle sustained.
- Write-to-read turnaround: a word written (granted) in t may be read-granted in t+1. The FIFO write lands before the read command reaches it, so ordering is preserved.
- Boundaries:
  - `level`=DEPTH: all `wr_gnt`=0 even with requests pending.
  - `level`=0: `rd_gnt`=0.
  - `level`=DEPTH−1 with both sides eligible: FSM priority decides; a write takes `level` to DEPTH.
- The FIFO's full/empty flags are not used for gating; the shadow count is authoritative.

## Structure
- Shared package `fifo_sched_pkg`:
  - FSM state typedef (PRIO_WR, PRIO_RD)
  - `DW` default constant
  - level width function clog2(DEPTH+1)
- One sub-module, `rr_arbiter`: NW-wide round-robin selector with inputs `req` and `rr` pointer, and outputs one-hot `gnt` and encoded index.
- FSM, counter, command register and read pipe stay in the top module.

## Test plan
- Reset release, no requests -> all outputs 0, `level`=0 for 10 cycles.
- Writer 0 streams 0..15 (NW=2, DEPTH=16) -> 16 consecutive `wr_gnt[0]`, `fifo_din` 0..15 one cycle later, `level`=16. A 17th request gets no grant.
- Both writers request continuously from empty -> grants alternate 0,1,0,1; `rr` wraps correctly.
- `level`=8, `wr_req[0]` and `rd_req` held 6 cycles -> grants W,R,W,R,W,R starting PRIO_WR; `level` ends at 8. Each `rd_valid` arrives 2 cycles after its `rd_gnt`, carrying data in FIFO order.
- `level`=0, read requested alone -> no `rd_gnt`. A write in t followed by a read in t+1 -> `rd_valid` at t+3 with the written value.
- `rstn` asserted while a read is in flight -> `rd_valid` never asserts for it; `level`=0, FSM=PRIO_WR, `rr`=0.
